// File: rtl/pi_bus_frontend.sv
// pi_bus_frontend
//   Pi-side front end for the 68K bridge. It synchronises the Pi GPIO read and
//   write strobes into the PI_CLK domain, decodes register writes (DATA,
//   ADDR_LO, ADDR_HI, STATUS), generates the address/data latch strobes,
//   captures the 68K operation fields and owns the transaction handshake.
//
// Ports
//   PI_CLK, RESET          : 200 MHz clock, asynchronous active-high reset
//   PI_A, PI_RD, PI_WR     : Pi register select and raw (async) strobes
//   PI_D_IN                : Pi data bus, input side
//   PI_D_OUT, PI_D_OE      : STATUS readback word and its output enable
//   IPL, RESET_IN          : 68K interrupt level / reset sense (already synced)
//   TXN_DONE               : one-cycle "bus cycle complete" from the bus FSM
//   LTCH_A_LO/A_HI/D_WR    : address/data latch strobes
//   LTCH_D_RD_OE_n         : read-data latch output enable (combinational)
//   TXN_START, TXN_BUSY    : new-cycle pulse and in-progress flag
//   OP_RW/UDS_n/LDS_n/FC   : 68K cycle direction, data strobes, function code
//   RESET_OUT, SM_RESET    : 68K reset request level, bus FSM reset pulse
module pi_bus_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int LTCH_PULSE  = 4
) (
  input  logic        PI_CLK,
  input  logic        RESET,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  input  logic [2:0]  IPL,
  input  logic        RESET_IN,
  input  logic        TXN_DONE,
  output logic        LTCH_A_LO,
  output logic        LTCH_A_HI,
  output logic        LTCH_D_WR,
  output logic        LTCH_D_RD_OE_n,
  output logic        TXN_START,
  output logic        TXN_BUSY,
  output logic        OP_RW,
  output logic        OP_UDS_n,
  output logic        OP_LDS_n,
  output logic [2:0]  OP_FC,
  output logic        RESET_OUT,
  output logic        SM_RESET
);

  localparam logic [3:0] PULSE_LOAD = 4'(LTCH_PULSE);
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic        wr_prev_q, wr_prev_d;
  logic        a0_q, a0_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        txn_start_q, txn_start_d;
  logic        sm_reset_q, sm_reset_d;
  logic        reset_out_q, reset_out_d;
  logic        op_rw_q, op_rw_d;
  logic        op_uds_n_q, op_uds_n_d;
  logic        op_lds_n_q, op_lds_n_d;
  logic [2:0]  op_fc_q, op_fc_d;
  logic [3:0]  cnt_d_wr_q, cnt_d_wr_d;
  logic [3:0]  cnt_a_lo_q, cnt_a_lo_d;
  logic [3:0]  cnt_a_hi_q, cnt_a_hi_d;
  logic        ltch_d_wr_q, ltch_d_wr_d;
  logic        ltch_a_lo_q, ltch_a_lo_d;
  logic        ltch_a_hi_q, ltch_a_hi_d;
  logic        pi_d_oe_q, pi_d_oe_d;
  logic [15:0] pi_d_out_q, pi_d_out_d;

  logic        wr_rise;
  logic        hi_write;
  logic        hi_accept;
  logic        unused_data_bits;

  // Data bits that carry no meaning in any register.
  assign unused_data_bits = ^{PI_D_IN[12:10], PI_D_IN[7:3]};

  // Next-state logic: synchronisers, write decode, latch counters,
  // transaction handshake and the registered STATUS read path.
  always_comb begin
    rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], PI_RD};
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], PI_WR};
    wr_prev_d   = wr_sync_q[SYNC_STAGES-1];
    wr_rise     = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;

    a0_d        = a0_q;
    overrun_d   = overrun_q;
    reset_out_d = reset_out_q;
    op_rw_d     = op_rw_q;
    op_uds_n_d  = op_uds_n_q;
    op_lds_n_d  = op_lds_n_q;
    op_fc_d     = op_fc_q;
    txn_start_d = 1'b0;
    sm_reset_d  = 1'b0;

    cnt_d_wr_d  = (cnt_d_wr_q != 4'd0) ? cnt_d_wr_q - 4'd1 : 4'd0;
    cnt_a_lo_d  = (cnt_a_lo_q != 4'd0) ? cnt_a_lo_q - 4'd1 : 4'd0;
    cnt_a_hi_d  = (cnt_a_hi_q != 4'd0) ? cnt_a_hi_q - 4'd1 : 4'd0;

    // A completion arriving on the same cycle frees the slot for the new
    // command, so the start is taken rather than flagged as an overrun.
    hi_write    = wr_rise && (PI_A == REG_ADDR_HI);
    hi_accept   = hi_write && (!busy_q || TXN_DONE);

    if (wr_rise) begin
      case (PI_A)
        REG_DATA: cnt_d_wr_d = PULSE_LOAD;
        REG_ADDR_LO: begin
          a0_d       = PI_D_IN[0];
          cnt_a_lo_d = PULSE_LOAD;
        end
        REG_ADDR_HI: begin
          if (hi_accept) begin
            op_rw_d     = PI_D_IN[9];
            op_fc_d     = PI_D_IN[15:13];
            op_uds_n_d  = PI_D_IN[8] ? a0_q : 1'b0;
            op_lds_n_d  = PI_D_IN[8] ? ~a0_q : 1'b0;
            cnt_a_hi_d  = PULSE_LOAD;
            txn_start_d = 1'b1;
          end else begin
            overrun_d   = 1'b1;
          end
        end
        default: begin
          reset_out_d = PI_D_IN[1];
          sm_reset_d  = PI_D_IN[0];
          if (PI_D_IN[2]) overrun_d = 1'b0;
        end
      endcase
    end

    // A start always wins; otherwise completion or a bus-FSM reset frees it.
    if (hi_accept)                  busy_d = 1'b1;
    else if (TXN_DONE || sm_reset_d) busy_d = 1'b0;
    else                            busy_d = busy_q;

    ltch_d_wr_d = (cnt_d_wr_d != 4'd0);
    ltch_a_lo_d = (cnt_a_lo_d != 4'd0);
    ltch_a_hi_d = (cnt_a_hi_d != 4'd0);

    pi_d_oe_d   = rd_sync_q[SYNC_STAGES-1] && (PI_A == REG_STATUS);
    pi_d_out_d  = {IPL, 10'b0, overrun_q, RESET_IN, 1'b0};
  end

  // State register; every output is a flop except LTCH_D_RD_OE_n.
  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      rd_sync_q   <= '0;
      wr_sync_q   <= '0;
      wr_prev_q   <= 1'b0;
      a0_q        <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      txn_start_q <= 1'b0;
      sm_reset_q  <= 1'b0;
      reset_out_q <= 1'b0;
      op_rw_q     <= 1'b1;
      op_uds_n_q  <= 1'b1;
      op_lds_n_q  <= 1'b1;
      op_fc_q     <= 3'b111;
      cnt_d_wr_q  <= 4'd0;
      cnt_a_lo_q  <= 4'd0;
      cnt_a_hi_q  <= 4'd0;
      ltch_d_wr_q <= 1'b0;
      ltch_a_lo_q <= 1'b0;
      ltch_a_hi_q <= 1'b0;
      pi_d_oe_q   <= 1'b0;
      pi_d_out_q  <= 16'd0;
    end else begin
      rd_sync_q   <= rd_sync_d;
      wr_sync_q   <= wr_sync_d;
      wr_prev_q   <= wr_prev_d;
      a0_q        <= a0_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      txn_start_q <= txn_start_d;
      sm_reset_q  <= sm_reset_d;
      reset_out_q <= reset_out_d;
      op_rw_q     <= op_rw_d;
      op_uds_n_q  <= op_uds_n_d;
      op_lds_n_q  <= op_lds_n_d;
      op_fc_q     <= op_fc_d;
      cnt_d_wr_q  <= cnt_d_wr_d;
      cnt_a_lo_q  <= cnt_a_lo_d;
      cnt_a_hi_q  <= cnt_a_hi_d;
      ltch_d_wr_q <= ltch_d_wr_d;
      ltch_a_lo_q <= ltch_a_lo_d;
      ltch_a_hi_q <= ltch_a_hi_d;
      pi_d_oe_q   <= pi_d_oe_d;
      pi_d_out_q  <= pi_d_out_d;
    end
  end

  // The read latch must open with no synchroniser delay, so it decodes the
  // raw pins; reset forces it closed like every other output.
  assign LTCH_D_RD_OE_n = RESET | ~((PI_A == REG_DATA) & PI_RD);

  assign PI_D_OUT  = pi_d_out_q;
  assign PI_D_OE   = pi_d_oe_q;
  assign LTCH_A_LO = ltch_a_lo_q;
  assign LTCH_A_HI = ltch_a_hi_q;
  assign LTCH_D_WR = ltch_d_wr_q;
  assign TXN_START = txn_start_q;
  assign TXN_BUSY  = busy_q;
  assign OP_RW     = op_rw_q;
  assign OP_UDS_n  = op_uds_n_q;
  assign OP_LDS_n  = op_lds_n_q;
  assign OP_FC     = op_fc_q;
  assign RESET_OUT = reset_out_q;
  assign SM_RESET  = sm_reset_q;

endmodule

// File: tb/tb_pi_bus_frontend.sv
// tb_pi_bus_frontend
//   Directed bench for pi_bus_frontend (SYNC_STAGES=2, LTCH_PULSE=4).
//   A table of register writes with hand-computed results is applied in a
//   loop, followed by hand-written sequences for strobe retriggering, the
//   TXN_DONE/start collision, STATUS control, the read path and mid-pulse reset.
`timescale 1ns/1ps
module tb_pi_bus_frontend;

  localparam int SYNC_STAGES = 2;
  localparam int LTCH_PULSE  = 4;

  logic        PI_CLK = 1'b0;
  logic        RESET;
  logic [1:0]  PI_A;
  logic        PI_RD, PI_WR;
  logic [15:0] PI_D_IN;
  logic [15:0] PI_D_OUT;
  logic        PI_D_OE;
  logic [2:0]  IPL;
  logic        RESET_IN, TXN_DONE;
  logic        LTCH_A_LO, LTCH_A_HI, LTCH_D_WR, LTCH_D_RD_OE_n;
  logic        TXN_START, TXN_BUSY, OP_RW, OP_UDS_n, OP_LDS_n;
  logic [2:0]  OP_FC;
  logic        RESET_OUT, SM_RESET;

  pi_bus_frontend #(.SYNC_STAGES(SYNC_STAGES), .LTCH_PULSE(LTCH_PULSE)) dut (
    .PI_CLK(PI_CLK), .RESET(RESET), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR),
    .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE), .IPL(IPL),
    .RESET_IN(RESET_IN), .TXN_DONE(TXN_DONE), .LTCH_A_LO(LTCH_A_LO),
    .LTCH_A_HI(LTCH_A_HI), .LTCH_D_WR(LTCH_D_WR), .LTCH_D_RD_OE_n(LTCH_D_RD_OE_n),
    .TXN_START(TXN_START), .TXN_BUSY(TXN_BUSY), .OP_RW(OP_RW),
    .OP_UDS_n(OP_UDS_n), .OP_LDS_n(OP_LDS_n), .OP_FC(OP_FC),
    .RESET_OUT(RESET_OUT), .SM_RESET(SM_RESET)
  );

  // 200 MHz clock.
  always #2.5 PI_CLK = ~PI_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_dwr, cnt_alo, cnt_ahi, cnt_start, cnt_smr, start_idx;

  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    logic        done_after;
    logic [2:0]  fc;
    logic        rw, uds_n, lds_n, busy, overrun;
    int          starts, dwr, alo, ahi;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // One Pi register write: strobe held 6 cycles, outputs observed for 12
  // cycles at the falling edge. Optionally pulses TXN_DONE on the cycle the
  // synchronised write edge is being decoded.
  task automatic apply_stimulus(input logic [1:0] a, input logic [15:0] d, input logic done_at_rise);
    @(negedge PI_CLK);
    PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
    cnt_dwr = 0; cnt_alo = 0; cnt_ahi = 0; cnt_start = 0; cnt_smr = 0; start_idx = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge PI_CLK);
      if (LTCH_D_WR) cnt_dwr++;
      if (LTCH_A_LO) cnt_alo++;
      if (LTCH_A_HI) cnt_ahi++;
      if (SM_RESET)  cnt_smr++;
      if (TXN_START) begin
        cnt_start++;
        if (start_idx < 0) start_idx = i;
      end
      if (i == SYNC_STAGES && done_at_rise) TXN_DONE = 1'b1;
      if (i == SYNC_STAGES + 1) TXN_DONE = 1'b0;
      if (i == 6) PI_WR = 1'b0;
    end
  endtask

  task automatic read_status(output logic [15:0] val, output logic oe);
    @(negedge PI_CLK);
    PI_A = 2'd3; PI_RD = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge PI_CLK);
    val = PI_D_OUT; oe = PI_D_OE;
    PI_RD = 1'b0;
    repeat (3) @(negedge PI_CLK);
  endtask

  task automatic pulse_done();
    @(negedge PI_CLK);
    TXN_DONE = 1'b1;
    @(negedge PI_CLK);
    TXN_DONE = 1'b0;
    @(negedge PI_CLK);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " PI_D_OUT"}, PI_D_OUT, 16'h0000);
    check_output({tag, " PI_D_OE"}, {15'b0, PI_D_OE}, 16'd0);
    check_output({tag, " strobes"}, {13'b0, LTCH_A_LO, LTCH_A_HI, LTCH_D_WR}, 16'd0);
    check_output({tag, " LTCH_D_RD_OE_n"}, {15'b0, LTCH_D_RD_OE_n}, 16'd1);
    check_output({tag, " TXN_START"}, {15'b0, TXN_START}, 16'd0);
    check_output({tag, " TXN_BUSY"}, {15'b0, TXN_BUSY}, 16'd0);
    check_output({tag, " OP"}, {10'b0, OP_RW, OP_UDS_n, OP_LDS_n, OP_FC}, 16'h003F);
    check_output({tag, " RESET_OUT"}, {15'b0, RESET_OUT}, 16'd0);
    check_output({tag, " SM_RESET"}, {15'b0, SM_RESET}, 16'd0);
  endtask

  initial begin
    logic [15:0] st;
    logic        oe;
    int          rises;
    logic        prev;

    //            a     d         done fc      rw    uds   lds   busy  ovr  st dwr alo ahi
    vecs[0] = '{2'd1, 16'h0001, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0};
    vecs[1] = '{2'd2, 16'hA100, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 4};
    vecs[2] = '{2'd2, 16'hE200, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 4};
    vecs[3] = '{2'd2, 16'h0300, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
    vecs[4] = '{2'd3, 16'h0004, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    vecs[5] = '{2'd1, 16'h0000, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0};
    vecs[6] = '{2'd2, 16'h2300, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, 4};
    vecs[7] = '{2'd0, 16'h1234, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4, 0, 0};

    RESET = 1'b1; PI_A = 2'd0; PI_RD = 1'b0; PI_WR = 1'b0; PI_D_IN = 16'h0;
    IPL = 3'b000; RESET_IN = 1'b0; TXN_DONE = 1'b0;
    repeat (3) @(negedge PI_CLK);
    check_reset_values("reset");
    RESET = 1'b0;
    repeat (2) @(negedge PI_CLK);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].d, 1'b0);
      check_output($sformatf("v%0d OP_FC", i), {13'b0, OP_FC}, {13'b0, vecs[i].fc});
      check_output($sformatf("v%0d OP_RW/UDS/LDS", i), {13'b0, OP_RW, OP_UDS_n, OP_LDS_n},
                   {13'b0, vecs[i].rw, vecs[i].uds_n, vecs[i].lds_n});
      check_output($sformatf("v%0d TXN_BUSY", i), {15'b0, TXN_BUSY}, {15'b0, vecs[i].busy});
      check_output($sformatf("v%0d TXN_START cycles", i), 16'(cnt_start), 16'(vecs[i].starts));
      if (vecs[i].starts == 1)
        check_output($sformatf("v%0d TXN_START latency", i), 16'(start_idx), 16'(SYNC_STAGES + 1));
      check_output($sformatf("v%0d LTCH_D_WR cycles", i), 16'(cnt_dwr), 16'(vecs[i].dwr));
      check_output($sformatf("v%0d LTCH_A_LO cycles", i), 16'(cnt_alo), 16'(vecs[i].alo));
      check_output($sformatf("v%0d LTCH_A_HI cycles", i), 16'(cnt_ahi), 16'(vecs[i].ahi));
      read_status(st, oe);
      check_output($sformatf("v%0d STATUS", i), st, {13'b0, vecs[i].overrun, 2'b00});
      check_output($sformatf("v%0d PI_D_OE", i), {15'b0, oe}, 16'd1);
      if (vecs[i].done_after) begin
        pulse_done();
        check_output($sformatf("v%0d busy after done", i), {15'b0, TXN_BUSY}, 16'd0);
      end
    end

    // Retrigger: two DATA write edges two cycles apart keep the strobe high
    // continuously for 2 + LTCH_PULSE cycles.
    @(negedge PI_CLK);
    PI_A = 2'd0; PI_D_IN = 16'h00FF; PI_WR = 1'b1;
    cnt_dwr = 0; rises = 0; prev = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge PI_CLK);
      if (LTCH_D_WR) cnt_dwr++;
      if (LTCH_D_WR && !prev) rises++;
      prev = LTCH_D_WR;
      if (i == 1) PI_WR = 1'b0;
      if (i == 2) PI_WR = 1'b1;
      if (i == 3) PI_WR = 1'b0;
    end
    check_output("retrigger LTCH_D_WR cycles", 16'(cnt_dwr), 16'(LTCH_PULSE + 2));
    check_output("retrigger LTCH_D_WR rises", 16'(rises), 16'd1);

    // TXN_DONE on the same cycle as an accepted ADDR_HI: the start wins.
    apply_stimulus(2'd2, 16'hE200, 1'b0);
    check_output("pre-collision busy", {15'b0, TXN_BUSY}, 16'd1);
    apply_stimulus(2'd2, 16'h4000, 1'b1);
    check_output("collision TXN_START cycles", 16'(cnt_start), 16'd1);
    check_output("collision TXN_BUSY", {15'b0, TXN_BUSY}, 16'd1);
    check_output("collision OP", {10'b0, OP_RW, OP_UDS_n, OP_LDS_n, OP_FC}, 16'h0002);
    read_status(st, oe);
    check_output("collision overrun", st, 16'h0000);

    // STATUS 0x0003: reset request level, one SM_RESET pulse, busy cleared.
    apply_stimulus(2'd3, 16'h0003, 1'b0);
    check_output("status SM_RESET cycles", 16'(cnt_smr), 16'd1);
    check_output("status RESET_OUT", {15'b0, RESET_OUT}, 16'd1);
    check_output("status TXN_BUSY", {15'b0, TXN_BUSY}, 16'd0);

    // Read path: registered STATUS word and the combinational read-latch OE.
    IPL = 3'b110; RESET_IN = 1'b1;
    @(negedge PI_CLK);
    PI_A = 2'd3; PI_RD = 1'b1;
    #1 check_output("rd OE_n while A=3", {15'b0, LTCH_D_RD_OE_n}, 16'd1);
    repeat (SYNC_STAGES + 2) @(negedge PI_CLK);
    check_output("rd PI_D_OE", {15'b0, PI_D_OE}, 16'd1);
    check_output("rd PI_D_OUT", PI_D_OUT, 16'hC002);
    PI_A = 2'd0;
    #1 check_output("rd LTCH_D_RD_OE_n", {15'b0, LTCH_D_RD_OE_n}, 16'd0);
    repeat (2) @(negedge PI_CLK);
    check_output("rd PI_D_OE A=0", {15'b0, PI_D_OE}, 16'd0);
    PI_RD = 1'b0;
    #1 check_output("rd OE_n released", {15'b0, LTCH_D_RD_OE_n}, 16'd1);

    // Reset in the middle of a LTCH_D_WR pulse with a transaction pending.
    apply_stimulus(2'd2, 16'hE200, 1'b0);
    @(negedge PI_CLK);
    PI_A = 2'd0; PI_D_IN = 16'h5555; PI_WR = 1'b1; PI_RD = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge PI_CLK);
    check_output("pre-reset LTCH_D_WR", {15'b0, LTCH_D_WR}, 16'd1);
    check_output("pre-reset TXN_BUSY", {15'b0, TXN_BUSY}, 16'd1);
    check_output("pre-reset RESET_OUT", {15'b0, RESET_OUT}, 16'd1);
    RESET = 1'b1;
    #0.5 check_reset_values("midreset");
    PI_WR = 1'b0; PI_RD = 1'b0;
    repeat (2) @(negedge PI_CLK);
    RESET = 1'b0;
    repeat (2) @(negedge PI_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
